la_operand_bank: RTL and testbench
==================================

LA_OPERAND_BANK -- requirements
Module: la_operand_bank

Interface
REQ-001 SHALL have parameter FIELD_W, default 163, operand width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 7, number of operand registers.
REQ-003 SHALL have parameter CHUNK_W, default 82, transfer chunk width; CHUNKS = ceil(FIELD_W/CHUNK_W); RW = clog2(NUM_REGS); CW = max(1, clog2(CHUNKS)).
REQ-004 SHALL have parameter PROC_CYCLES, default 2000, processing timeout in cycles.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 cmd_valid  input  1  command strobe.
REQ-008 cmd_ready  output  1  command accept; a command is accepted when cmd_valid && cmd_ready.
REQ-009 cmd_op  input  3  0=OPEN, 1=WRITE, 2=START, 3=READ, 4=CLOSE; 5-7 illegal.
REQ-010 cmd_addr  input  RW+CW  {reg_idx, chunk_idx}.
REQ-011 cmd_data  input  CHUNK_W  write chunk.
REQ-012 rsp_valid  output  1  read response strobe.
REQ-013 rsp_data  output  CHUNK_W  read chunk.
REQ-014 core_start  output  1  one-cycle pulse starting the arithmetic core.
REQ-015 core_operands  output  NUM_REGS*FIELD_W  register r at bits [r*FIELD_W +: FIELD_W].
REQ-016 core_wr_en, core_wr_idx, core_wr_data  input  1, RW, FIELD_W  core result write-back.
REQ-017 core_done  input  1  core completion.
REQ-018 state  output  2  IDLE=00, LOAD=01, PROC=11, READ=10.
REQ-019 err, timeout  output  1, 1  sticky error and timeout flags.

Function
REQ-020 FSM transitions SHALL be: IDLE-OPEN->LOAD; LOAD-START (all chunks loaded)->PROC; PROC-core_done->READ; PROC-timeout->READ; READ-CLOSE->IDLE.
REQ-021 Accepted OPEN in IDLE SHALL clear all registers and load mask, and clear err and timeout.
REQ-022 Accepted WRITE in LOAD SHALL write cmd_data into register reg_idx bits [chunk_idx*CHUNK_W +: CHUNK_W], truncated at FIELD_W, and set that chunk's mask bit; data bits above FIELD_W are discarded.
REQ-023 Writing the same chunk again SHALL overwrite it; no error.
REQ-024 START with any mask bit clear SHALL set err and remain in LOAD.
REQ-025 reg_idx >= NUM_REGS or chunk_idx >= CHUNKS on WRITE/READ SHALL set err, with no register write and no rsp_valid.
REQ-026 Any op not listed for the current state, including 5-7, SHALL set err and be otherwise ignored.
REQ-027 cmd_ready SHALL be 0 in PROC and 1 in all other states.
REQ-028 core_start SHALL be 1 exactly in the first PROC cycle.
REQ-029 core_operands SHALL continuously reflect the registers.
REQ-030 core_wr_en in PROC SHALL write core_wr_data to register core_wr_idx; core_wr_idx >= NUM_REGS SHALL be ignored; core_wr_en outside PROC SHALL be ignored.
REQ-031 A PROC cycle counter SHALL start at 0 on entry; if it reaches PROC_CYCLES-1 without core_done, the FSM SHALL go to READ and set timeout.
REQ-032 If core_done and the last counter cycle coincide, core_done SHALL win: timeout stays 0.
REQ-033 A core_wr_en in the same cycle as core_done SHALL still be written.
REQ-034 Accepted READ in READ SHALL assert rsp_valid for exactly one cycle, on the next cycle, with rsp_data = selected chunk, bits beyond FIELD_W returned as 0.
REQ-035 Back-to-back READs SHALL give back-to-back responses in order.
REQ-036 Outside REQ-034, rsp_valid SHALL be 0; rsp_data SHALL hold its last value.

Reset
REQ-037 On rst SHALL force state=IDLE; registers, mask, PROC counter, rsp_data = 0; rsp_valid, core_start, err, timeout = 0.
REQ-038 rst SHALL override any command or core input in the same cycle, in any state, including mid-PROC.

Verification
REQ-039 OPEN; WRITE all 14 chunks with reg r chunk 0 = r+1 and chunk 1 = 0x100+r; START -> state=11, core_start high one cycle, reg 2 on core_operands = {chunk1[80:0], chunk0 = 82'h3}.
REQ-040 OPEN; write 13 chunks; START -> err=1, state=01; write the last chunk; START -> state=11.
REQ-041 In PROC, core_wr_en=1, idx=0, data=163'h5A, same cycle as core_done -> READ; READ addr 0 -> rsp_valid one cycle later, rsp_data=82'h5A, timeout=0.
REQ-042 In PROC, no core_done -> after 2000 cycles state=10, timeout=1; READ addr {3'd1,1'b1} -> bits [81:81] of rsp_data = 0.
REQ-043 WRITE with reg_idx=7 -> err=1, no register change; op=6 in IDLE -> err=1, state=00.
REQ-044 rst asserted mid-PROC at cycle 500 -> next cycle state=00, core_operands all 0, cmd_ready=1.

Source files
------------

// File: rtl/la_operand_bank.sv
// Operand register bank for a large-field arithmetic core. Operands are loaded in chunks,
// handed to the core for processing, then read back in chunks.
module la_operand_bank #(
  parameter  int FIELD_W     = 163,
  parameter  int NUM_REGS    = 7,
  parameter  int CHUNK_W     = 82,
  parameter  int PROC_CYCLES = 2000,
  localparam int CHUNKS      = (FIELD_W + CHUNK_W - 1) / CHUNK_W,
  localparam int RW          = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int CW          = (CHUNKS > 1) ? $clog2(CHUNKS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [2:0]                   cmd_op,
  input  logic [RW+CW-1:0]             cmd_addr,
  input  logic [CHUNK_W-1:0]           cmd_data,
  output logic                         rsp_valid,
  output logic [CHUNK_W-1:0]           rsp_data,
  output logic                         core_start,
  output logic [NUM_REGS*FIELD_W-1:0]  core_operands,
  input  logic                         core_wr_en,
  input  logic [RW-1:0]                core_wr_idx,
  input  logic [FIELD_W-1:0]           core_wr_data,
  input  logic                         core_done,
  output logic [1:0]                   state,
  output logic                         err,
  output logic                         timeout
);

  localparam int PAD_W = CHUNKS * CHUNK_W;
  localparam int CNT_W = (PROC_CYCLES > 1) ? $clog2(PROC_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PROC_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_PROC = 2'b11,
    S_READ = 2'b10
  } state_e;

  typedef enum logic [2:0] {
    OP_OPEN  = 3'd0,
    OP_WRITE = 3'd1,
    OP_START = 3'd2,
    OP_READ  = 3'd3,
    OP_CLOSE = 3'd4
  } op_e;

  // A register zero-padded to a whole number of chunks, viewed chunk by chunk.
  typedef logic [CHUNKS-1:0][CHUNK_W-1:0] chunk_vec_t;

  function automatic logic [FIELD_W-1:0] put_chunk(input logic [FIELD_W-1:0] r,
                                                   input logic [CW-1:0]      ci,
                                                   input logic [CHUNK_W-1:0] d);
    chunk_vec_t v;
    v     = chunk_vec_t'(PAD_W'(r));
    v[ci] = d;
    return FIELD_W'(v);
  endfunction

  function automatic logic [CHUNK_W-1:0] get_chunk(input logic [FIELD_W-1:0] r,
                                                   input logic [CW-1:0]      ci);
    chunk_vec_t v;
    v = chunk_vec_t'(PAD_W'(r));
    return v[ci];
  endfunction

  state_e                          state_q;
  logic [FIELD_W-1:0]              regs_q [NUM_REGS];
  logic [NUM_REGS-1:0][CHUNKS-1:0] mask_q;
  logic [CNT_W-1:0]                cnt_q;
  logic                            rsp_valid_q;
  logic [CHUNK_W-1:0]              rsp_data_q;
  logic                            core_start_q;
  logic                            err_q;
  logic                            timeout_q;

  logic [RW-1:0] reg_idx;
  logic [CW-1:0] chunk_idx;
  logic          addr_ok;
  logic          wr_idx_ok;
  logic          cmd_fire;

  assign reg_idx   = cmd_addr[RW+CW-1:CW];
  assign chunk_idx = cmd_addr[CW-1:0];
  assign addr_ok   = (int'(reg_idx) < NUM_REGS) && (int'(chunk_idx) < CHUNKS);
  assign wr_idx_ok = int'(core_wr_idx) < NUM_REGS;
  assign cmd_ready = (state_q != S_PROC);
  assign cmd_fire  = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      // NOTE: the register array is reset because the core sees it continuously and a
      // cleared bank is part of the reset state; it is small enough to live in flops.
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
      mask_q       <= '0;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      core_start_q <= 1'b0;
      err_q        <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      // NOTE: all state here uses non-blocking assignment so every read sees the
      // pre-edge value, independent of statement order.
      rsp_valid_q  <= 1'b0;
      core_start_q <= 1'b0;
      case (state_q)
        S_IDLE: if (cmd_fire) begin
          if (op_e'(cmd_op) == OP_OPEN) begin
            for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
            mask_q    <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
            state_q   <= S_LOAD;
          end else begin
            err_q <= 1'b1;
          end
        end
        S_LOAD: if (cmd_fire) begin
          case (op_e'(cmd_op))
            OP_WRITE: begin
              if (addr_ok) begin
                regs_q[reg_idx]            <= put_chunk(regs_q[reg_idx], chunk_idx, cmd_data);
                mask_q[reg_idx][chunk_idx] <= 1'b1;
              end else begin
                err_q <= 1'b1;
              end
            end
            OP_START: begin
              if (&mask_q) begin
                cnt_q        <= '0;
                core_start_q <= 1'b1;
                state_q      <= S_PROC;
              end else begin
                err_q <= 1'b1;
              end
            end
            default: err_q <= 1'b1;
          endcase
        end
        S_PROC: begin
          if (core_wr_en && wr_idx_ok) regs_q[core_wr_idx] <= core_wr_data;
          // core_done takes priority over an expiring counter.
          if (core_done) begin
            state_q <= S_READ;
          end else if (cnt_q == CNT_LAST) begin
            timeout_q <= 1'b1;
            state_q   <= S_READ;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_READ: if (cmd_fire) begin
          case (op_e'(cmd_op))
            OP_READ: begin
              if (addr_ok) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= get_chunk(regs_q[reg_idx], chunk_idx);
              end else begin
                err_q <= 1'b1;
              end
            end
            OP_CLOSE: state_q <= S_IDLE;
            default:  err_q   <= 1'b1;
          endcase
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_ops
    assign core_operands[g*FIELD_W +: FIELD_W] = regs_q[g];
  end

  assign state      = state_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign core_start = core_start_q;
  assign err        = err_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_la_operand_bank.sv
// Randomized bench for la_operand_bank: a bit-level reference model of the register bank
// feeds a response queue that an independent monitor drains on every rsp_valid.
module tb_la_operand_bank;

  localparam int FIELD_W     = 163;
  localparam int NUM_REGS    = 7;
  localparam int CHUNK_W     = 82;
  localparam int PROC_CYCLES = 2000;
  localparam int CHUNKS      = 2;

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         cmd_valid;
  logic                         cmd_ready;
  logic [2:0]                   cmd_op;
  logic [3:0]                   cmd_addr;
  logic [CHUNK_W-1:0]           cmd_data;
  logic                         rsp_valid;
  logic [CHUNK_W-1:0]           rsp_data;
  logic                         core_start;
  logic [NUM_REGS*FIELD_W-1:0]  core_operands;
  logic                         core_wr_en;
  logic [2:0]                   core_wr_idx;
  logic [FIELD_W-1:0]           core_wr_data;
  logic                         core_done;
  logic [1:0]                   state;
  logic                         err;
  logic                         timeout;

  la_operand_bank #(
    .FIELD_W(FIELD_W), .NUM_REGS(NUM_REGS), .CHUNK_W(CHUNK_W), .PROC_CYCLES(PROC_CYCLES)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .core_start(core_start), .core_operands(core_operands),
    .core_wr_en(core_wr_en), .core_wr_idx(core_wr_idx), .core_wr_data(core_wr_data),
    .core_done(core_done), .state(state), .err(err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Reference model: registers as plain bit arrays, one loaded flag per chunk.
  logic [FIELD_W-1:0] m_reg [NUM_REGS];
  bit                 m_mask [NUM_REGS][CHUNKS];
  logic               exp_err;
  logic [CHUNK_W-1:0] exp_q [$];
  int                 n_cmp = 0;
  int                 n_bad = 0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [CHUNK_W-1:0] rnd_chunk();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[CHUNK_W-1:0];
  endfunction

  function automatic logic [FIELD_W-1:0] rnd_field();
    logic [191:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[FIELD_W-1:0];
  endfunction

  task automatic m_clear();
    for (int r = 0; r < NUM_REGS; r++) begin
      m_reg[r] = '0;
      for (int c = 0; c < CHUNKS; c++) m_mask[r][c] = 1'b0;
    end
  endtask

  task automatic m_write(input int r, input int c, input logic [CHUNK_W-1:0] d);
    for (int b = 0; b < CHUNK_W; b++)
      if (c * CHUNK_W + b < FIELD_W) m_reg[r][c * CHUNK_W + b] = d[b];
    m_mask[r][c] = 1'b1;
  endtask

  function automatic logic [CHUNK_W-1:0] m_read(input int r, input int c);
    logic [CHUNK_W-1:0] v;
    v = '0;
    for (int b = 0; b < CHUNK_W; b++)
      if (c * CHUNK_W + b < FIELD_W) v[b] = m_reg[r][c * CHUNK_W + b];
    return v;
  endfunction

  task automatic check_ops(input string tag);
    for (int r = 0; r < NUM_REGS; r++)
      check($sformatf("%s reg%0d", tag, r), 192'(core_operands[r*FIELD_W +: FIELD_W]),
            192'(m_reg[r]));
  endtask

  // Called at a falling edge; returns at the next falling edge after the command is taken.
  task automatic do_cmd(input logic [2:0] op, input logic [3:0] addr,
                        input logic [CHUNK_W-1:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [CHUNK_W-1:0] d);
    int r;
    r = int'(addr[3:1]);
    if (r < NUM_REGS) m_write(r, int'(addr[0]), d);
    else exp_err = 1'b1;
    do_cmd(3'd1, addr, d);
  endtask

  task automatic rd(input logic [3:0] addr);
    int r;
    r = int'(addr[3:1]);
    if (r < NUM_REGS) exp_q.push_back(m_read(r, int'(addr[0])));
    else exp_err = 1'b1;
    do_cmd(3'd3, addr, '0);
  endtask

  task automatic open_bank();
    m_clear();
    exp_err = 1'b0;
    do_cmd(3'd0, '0, '0);
  endtask

  task automatic fill_random();
    for (int r = 0; r < NUM_REGS; r++)
      for (int c = 0; c < CHUNKS; c++) wr(4'(r * 2 + c), rnd_chunk());
  endtask

  // Monitor: every response the DUT presents must match the oldest expected read.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rsp: got %0h, expected no response", rsp_data);
      end else begin
        check("rsp_data", 192'(rsp_data), 192'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0;
    core_wr_en = 1'b0; core_wr_idx = '0; core_wr_data = '0; core_done = 1'b0;
    m_clear();
    exp_err = 1'b0;
    repeat (3) @(negedge clk);

    check("rst state", 192'(state), 192'(2'b00));
    check("rst cmd_ready", 192'(cmd_ready), 192'(1'b1));
    check("rst err", 192'(err), 192'(1'b0));
    check("rst timeout", 192'(timeout), 192'(1'b0));
    check("rst core_start", 192'(core_start), 192'(1'b0));
    check("rst rsp_valid", 192'(rsp_valid), 192'(1'b0));
    check("rst rsp_data", 192'(rsp_data), 192'(0));
    check_ops("rst");
    rst = 1'b0;
    @(negedge clk);

    // Illegal opcode in IDLE.
    do_cmd(3'd6, '0, '0);
    check("idle op6 err", 192'(err), 192'(1'b1));
    check("idle op6 state", 192'(state), 192'(2'b00));

    // Directed load, start and core completion.
    open_bank();
    check("open state", 192'(state), 192'(2'b01));
    check("open clears err", 192'(err), 192'(1'b0));
    for (int r = 0; r < NUM_REGS; r++) begin
      wr(4'(r * 2), CHUNK_W'(r + 1));
      wr(4'(r * 2 + 1), CHUNK_W'(32'h100 + r));
    end
    check_ops("loaded");
    do_cmd(3'd2, '0, '0);
    check("start state", 192'(state), 192'(2'b11));
    check("start core_start", 192'(core_start), 192'(1'b1));
    check("proc cmd_ready", 192'(cmd_ready), 192'(1'b0));
    check("reg2 layout", 192'(core_operands[2*FIELD_W +: FIELD_W]), 192'({81'h102, 82'h3}));
    @(negedge clk);
    check("core_start one cycle", 192'(core_start), 192'(1'b0));
    check("still proc", 192'(state), 192'(2'b11));

    core_wr_en = 1'b1; core_wr_idx = 3'd0; core_wr_data = 163'h5A; core_done = 1'b1;
    @(negedge clk);
    core_wr_en = 1'b0; core_done = 1'b0;
    m_reg[0] = 163'h5A;
    check("done state", 192'(state), 192'(2'b10));
    check("done timeout", 192'(timeout), 192'(1'b0));
    check_ops("done wb");

    rd(4'd0);
    @(negedge clk);
    check("rsp one cycle", 192'(rsp_valid), 192'(1'b0));
    check("rsp_data holds", 192'(rsp_data), 192'(82'h5A));
    for (int i = 0; i < 10; i++) rd(4'($urandom_range(0, 13)));
    @(negedge clk);

    core_wr_en = 1'b1; core_wr_idx = 3'd1; core_wr_data = rnd_field();
    @(negedge clk);
    core_wr_en = 1'b0;
    check_ops("wr outside proc");

    rd({3'd7, 1'b0});
    check("bad read err", 192'(err), 192'(exp_err));
    do_cmd(3'd4, '0, '0);
    check("close state", 192'(state), 192'(2'b00));

    // Incomplete load, rejected write, then timeout with random core write-backs.
    open_bank();
    check("reopen err", 192'(err), 192'(1'b0));
    for (int r = 0; r < NUM_REGS; r++)
      for (int c = 0; c < CHUNKS; c++)
        if (!(r == 6 && c == 1)) wr(4'(r * 2 + c), rnd_chunk());
    wr(4'd0, rnd_chunk());
    check("overwrite no err", 192'(err), 192'(1'b0));
    do_cmd(3'd2, '0, '0);
    check("early start err", 192'(err), 192'(1'b1));
    check("early start state", 192'(state), 192'(2'b01));
    exp_err = 1'b1;
    wr({3'd7, 1'b0}, rnd_chunk());
    check_ops("bad write");
    do_cmd(3'd0, '0, '0);
    check("open in load state", 192'(state), 192'(2'b01));
    wr({3'd6, 1'b1}, rnd_chunk());
    do_cmd(3'd2, '0, '0);
    check("late start state", 192'(state), 192'(2'b11));

    for (int k = 1; k < PROC_CYCLES; k++) begin
      if (k <= 60) begin
        core_wr_en   = 1'($urandom_range(0, 1));
        core_wr_idx  = 3'($urandom_range(0, 7));
        core_wr_data = rnd_field();
      end else begin
        core_wr_en = 1'b0;
      end
      @(negedge clk);
      if (core_wr_en && int'(core_wr_idx) < NUM_REGS) m_reg[core_wr_idx] = core_wr_data;
    end
    core_wr_en = 1'b0;
    check("last proc cycle", 192'(state), 192'(2'b11));
    @(negedge clk);
    check("timeout state", 192'(state), 192'(2'b10));
    check("timeout flag", 192'(timeout), 192'(1'b1));
    check_ops("after timeout");
    rd({3'd1, 1'b1});
    check("pad bit zero", 192'(rsp_data[81]), 192'(1'b0));
    for (int i = 0; i < 8; i++) rd(4'($urandom_range(0, 13)));
    do_cmd(3'd4, '0, '0);

    // core_done on the final counter cycle beats the timeout; random writes first.
    open_bank();
    for (int i = 0; i < 20; i++) wr(4'($urandom_range(0, 15)), rnd_chunk());
    check("random load err", 192'(err), 192'(exp_err));
    fill_random();
    do_cmd(3'd2, '0, '0);
    repeat (PROC_CYCLES - 1) @(negedge clk);
    check("edge proc", 192'(state), 192'(2'b11));
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    check("edge done state", 192'(state), 192'(2'b10));
    check("edge done timeout", 192'(timeout), 192'(1'b0));
    for (int i = 0; i < 6; i++) rd(4'($urandom_range(0, 13)));
    do_cmd(3'd4, '0, '0);

    // Reset in the middle of processing, alongside a core_done.
    open_bank();
    fill_random();
    do_cmd(3'd2, '0, '0);
    repeat (499) @(negedge clk);
    rst = 1'b1; core_done = 1'b1;
    @(negedge clk);
    rst = 1'b0; core_done = 1'b0;
    m_clear();
    check("midproc rst state", 192'(state), 192'(2'b00));
    check("midproc rst cmd_ready", 192'(cmd_ready), 192'(1'b1));
    check("midproc rst timeout", 192'(timeout), 192'(1'b0));
    check_ops("midproc rst");

    repeat (3) @(negedge clk);
    check("pending responses", 192'(exp_q.size()), 192'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
